// File: rtl/dp_pkg.sv
// Shared types for the self-sequencing datapath: opcodes, shift modes, FSM states, status bits.
// Helpers classify ops that write a register or may skip the operand-read states.
package dp_pkg;

  typedef enum logic [2:0] {
    OP_MOVI = 3'd0,
    OP_MOV  = 3'd1,
    OP_ADD  = 3'd2,
    OP_CMP  = 3'd3,
    OP_AND  = 3'd4,
    OP_MVN  = 3'd5,
    OP_LDM  = 3'd6,
    OP_NOP  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'd0,
    SH_LSL1 = 2'd1,
    SH_LSR1 = 2'd2,
    SH_ASR1 = 2'd3
  } shift_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EXE  = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_V = 2;

  function automatic logic op_writes(input op_e op);
    return !(op == OP_CMP || op == OP_NOP);
  endfunction

  // Ops whose result does not depend on A or B.
  function automatic logic op_is_fast(input op_e op);
    return (op == OP_MOVI || op == OP_LDM || op == OP_NOP);
  endfunction

endpackage

// File: rtl/dp_seq_datapath_if.sv
// Command/response bundle between decoder (master) and datapath (slave).
// mdata travels with the command side since the decoder's memory path supplies it.
interface dp_seq_datapath_if #(
  parameter int DW   = 16,
  parameter int NREG = 8
);
  localparam int AW = $clog2(NREG);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rn;
  logic [AW-1:0] cmd_rm;
  logic [1:0]    cmd_shift;
  logic [DW-1:0] cmd_imm;
  logic [DW-1:0] mdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [2:0]    status;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm, mdata,
    input  cmd_ready, rsp_valid, rsp_data, status
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm, mdata,
    output cmd_ready, rsp_valid, rsp_data, status
  );
endinterface

// File: rtl/dp_regfile.sv
// General register array: async-reset storage, one synchronous write port, one combinational read port.
module dp_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [DW-1:0]           wdata,
  input  logic [$clog2(NREG)-1:0] raddr,
  output logic [DW-1:0]           rdata
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];

endmodule

// File: rtl/dp_seq_datapath.sv
// Self-sequencing datapath: IDLE -> RDA -> RDB -> EXE -> WB, one command per 5 cycles, rsp_valid 1-cycle pulse.
// Define DP_FASTPATH_EN to let MOVI/LDM/NOP jump IDLE -> EXE (A/B left untouched).
module dp_seq_datapath
  import dp_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  dp_seq_datapath_if.slave    bus
);

  localparam int AW = $clog2(NREG);

  state_e        state_q, state_d;
  op_e           op_q;
  shift_e        shift_q;
  logic [AW-1:0] rd_q, rn_q, rm_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a_q, b_q, c_q;
  logic [2:0]    status_q;
  logic          rsp_valid_q;

  logic          accept;
  logic [DW-1:0] bs, diff, result;
  logic [2:0]    cmp_flags;
  logic          rf_we;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
`ifdef DP_FASTPATH_EN
          state_d = op_is_fast(op_e'(bus.cmd_op)) ? ST_EXE : ST_RDA;
`else
          state_d = ST_RDA;
`endif
        end
      end
      ST_RDA:  state_d = ST_RDB;
      ST_RDB:  state_d = ST_EXE;
      ST_EXE:  state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bs = b_q;
    case (shift_q)
      SH_LSL1: bs = {b_q[DW-2:0], 1'b0};
      SH_LSR1: bs = {1'b0, b_q[DW-1:1]};
      SH_ASR1: bs = {b_q[DW-1], b_q[DW-1:1]};
      default: bs = b_q;
    endcase
  end

  always_comb begin
    diff   = a_q - bs;
    result = c_q;
    case (op_q)
      OP_MOVI: result = imm_q;
      OP_MOV:  result = bs;
      OP_ADD:  result = a_q + bs;
      OP_CMP:  result = diff;
      OP_AND:  result = a_q & bs;
      OP_MVN:  result = ~bs;
      OP_LDM:  result = bus.mdata;
      default: result = c_q;
    endcase
    cmp_flags         = '0;
    cmp_flags[STAT_Z] = (diff == '0);
    cmp_flags[STAT_N] = diff[DW-1];
    cmp_flags[STAT_V] = (a_q[DW-1] != bs[DW-1]) && (diff[DW-1] != a_q[DW-1]);
  end

  // Command fields are only captured on accept, so changes while busy are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_MOVI;
      shift_q     <= SH_NONE;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      status_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= (state_q == ST_WB);
      if (accept) begin
        op_q    <= op_e'(bus.cmd_op);
        shift_q <= shift_e'(bus.cmd_shift);
        rd_q    <= bus.cmd_rd;
        rn_q    <= bus.cmd_rn;
        rm_q    <= bus.cmd_rm;
        imm_q   <= bus.cmd_imm;
      end
      if (state_q == ST_RDA) a_q <= rf_rdata;
      if (state_q == ST_RDB) b_q <= rf_rdata;
      if (state_q == ST_EXE) begin
        c_q <= result;
        if (op_q == OP_CMP) status_q <= cmp_flags;
      end
    end
  end

  assign rf_raddr = (state_q == ST_RDA) ? rn_q : rm_q;
  assign rf_we    = (state_q == ST_WB) && op_writes(op_q);

  dp_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .waddr (rd_q),
    .wdata (c_q),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = c_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_dp_seq_datapath.sv
// Directed plus randomized bench for dp_seq_datapath against an arithmetic reference model.
module tb_dp_seq_datapath;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] mr [8];
  logic [15:0] mc;
  logic [2:0]  mstat;

  dp_seq_datapath_if #(.DW(16), .NREG(8)) bus ();

  dp_seq_datapath #(.DW(16), .NREG(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int op);
`ifdef DP_FASTPATH_EN
    if (op == 0 || op == 6 || op == 7) return 2;
`endif
    return 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mr[i] = 16'h0;
    mc    = 16'h0;
    mstat = 3'b000;
  endtask

  // Runs one command to completion; checks latency, busy window, result, status and pulse width.
  task automatic run_cmd(input string tag, input int op, input int rd, input int rn, input int rm,
                         input int sh, input logic [15:0] imm, input logic [15:0] md,
                         output logic [15:0] data);
    logic [15:0] a, b, bs, res, diff;
    logic [2:0]  st;
    int          e0, lowcnt, n;
    bit          got;
    a  = mr[rn];
    b  = mr[rm];
    case (sh)
      1:       bs = b << 1;
      2:       bs = b >> 1;
      3:       bs = 16'($signed(b) >>> 1);
      default: bs = b;
    endcase
    diff = a - bs;
    st   = mstat;
    case (op)
      0: res = imm;
      1: res = bs;
      2: res = a + bs;
      3: begin
        res = diff;
        st  = {(a[15] != bs[15]) && (diff[15] != a[15]), diff[15], diff == 16'h0};
      end
      4: res = a & bs;
      5: res = ~bs;
      6: res = md;
      default: res = mc;
    endcase

    @(negedge clk);
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      failures++;
      $display("FAIL %s_ready_timeout observed=0 expected=1", tag);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_rd    = 3'(rd);
    bus.cmd_rn    = 3'(rn);
    bus.cmd_rm    = 3'(rm);
    bus.cmd_shift = 2'(sh);
    bus.cmd_imm   = imm;
    bus.mdata     = md;
    e0     = cyc + 1;
    lowcnt = 0;
    got    = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
      else if (!bus.cmd_ready) lowcnt++;
      if (bus.cmd_ready) begin
        bus.cmd_valid = 1'b0;
      end else begin
        bus.cmd_valid = 1'($urandom);
        bus.cmd_op    = 3'($urandom);
        bus.cmd_rd    = 3'($urandom);
        bus.cmd_rn    = 3'($urandom);
        bus.cmd_rm    = 3'($urandom);
        bus.cmd_shift = 2'($urandom);
        bus.cmd_imm   = 16'($urandom);
      end
    end
    check({tag, "_rsp_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc - e0), 32'(exp_lat(op)));
    check({tag, "_busy_cycles"}, 32'(lowcnt), 32'(exp_lat(op)));
    check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(res));
    check({tag, "_status"}, 32'(bus.status), 32'(st));
    data = bus.rsp_data;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    mc    = res;
    mstat = st;
    if (op != 3 && op != 7) mr[rd] = res;
  endtask

  task automatic read_all(input string tag);
    logic [15:0] d;
    for (int i = 0; i < 8; i++) begin
      run_cmd({tag, "_rd", $sformatf("%0d", i)}, 1, i, i, i, 0, 16'h0, 16'h0, d);
      check({tag, "_reg", $sformatf("%0d", i)}, 32'(d), 32'(mr[i]));
    end
  endtask

  initial begin
    logic [15:0] d;
    int          acc [3];
    int          idx, pulses, seen;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd7;
    bus.cmd_rd    = 3'd0;
    bus.cmd_rn    = 3'd0;
    bus.cmd_rm    = 3'd0;
    bus.cmd_shift = 2'd0;
    bus.cmd_imm   = 16'h0;
    bus.mdata     = 16'h0;
    model_reset();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_status", 32'(bus.status), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);

    // Latency and basic moves/shifts.
    run_cmd("movi_r1", 0, 1, 0, 0, 0, 16'h0002, 16'h0, d);
    check("movi_r1_const", 32'(d), 32'h0002);
    run_cmd("movi_r0", 0, 0, 0, 0, 0, 16'h0007, 16'h0, d);
    run_cmd("mov_lsl", 1, 2, 0, 1, 1, 16'h0, 16'h0, d);
    check("mov_lsl_const", 32'(d), 32'h0004);
    run_cmd("add_asr", 2, 3, 0, 1, 3, 16'h0, 16'h0, d);
    check("add_asr_const", 32'(d), 32'h0008);
    check("add_status_const", 32'(bus.status), 32'h0);

    // CMP flags, no register write.
    run_cmd("movi_7fff", 0, 0, 0, 0, 0, 16'h7FFF, 16'h0, d);
    run_cmd("movi_ffff", 0, 1, 0, 0, 0, 16'hFFFF, 16'h0, d);
    run_cmd("cmp_ovf", 3, 5, 0, 1, 0, 16'h0, 16'h0, d);
    check("cmp_ovf_data", 32'(d), 32'h8000);
    check("cmp_ovf_vnz", 32'(bus.status), 32'b110);
    run_cmd("cmp_eq", 3, 5, 0, 0, 0, 16'h0, 16'h0, d);
    check("cmp_eq_vnz", 32'(bus.status), 32'b001);
    run_cmd("nop", 7, 6, 0, 0, 0, 16'h1234, 16'h0, d);
    check("nop_keeps_c", 32'(d), 32'h0);
    read_all("cmp");

    // LDM (fast path when enabled).
    run_cmd("ldm_r4", 6, 4, 0, 0, 0, 16'h0, 16'hBEEF, d);
    check("ldm_r4_const", 32'(d), 32'hBEEF);

    // Back-to-back MOVIs with cmd_valid held high.
    idx = 0; pulses = 0; seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
      if (idx < 3) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_rd    = 3'(5 + idx);
        bus.cmd_shift = 2'd0;
        bus.cmd_imm   = 16'h0A00 + 16'(idx);
        if (bus.cmd_ready) begin
          acc[idx] = cyc + 1;
          idx++;
        end
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end
    check("hs_accepts", 32'(idx), 32'd3);
    check("hs_gap01", 32'(acc[1] - acc[0]), 32'(exp_lat(0) + 1));
    check("hs_gap12", 32'(acc[2] - acc[1]), 32'(exp_lat(0) + 1));
    check("hs_pulses", 32'(pulses), 32'd3);
    for (int i = 0; i < 3; i++) mr[5 + i] = 16'h0A00 + 16'(i);
    mc = 16'h0A02;
    read_all("hs");

    // Randomized commands against the model.
    for (int t = 0; t < 40; t++) begin
      run_cmd($sformatf("rand%0d", t), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              16'($urandom), 16'($urandom), d);
    end
    read_all("rand");

    // Ensure status is nonzero, then reset during RDB of an ADD.
    run_cmd("pre_rst_cmp", 3, 0, 0, 0, 0, 16'h0, 16'h0, d);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd2;
    bus.cmd_rd    = 3'd1;
    bus.cmd_rn    = 3'd2;
    bus.cmd_rm    = 3'd3;
    bus.cmd_shift = 2'd0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    seen = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("rst_no_rsp", 32'(seen), 32'd0);
    check("rst_status", 32'(bus.status), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    model_reset();
    read_all("rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
